// File: rtl/ssbr_deser_4.sv
// ssbr_deser_4: consumer of the bidirectional serial shift register's output.
// Waits out the register's pipeline delay after a start pulse. Reassembles the
// serial stream into WIDTH-bit words, LSB first when shifting right and MSB
// first when shifting left. Delivers the words through a 2-entry buffer with a
// valid/ready handshake.
module ssbr_deser_4 #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_in,
    input  logic             dir,
    input  logic             start,
    input  logic [2:0]       nwords,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overflow,
    output logic             frame_err,
    input  logic             clr_err
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int AW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ALIGN, COLLECT} state_t;

    state_t           state;
    state_t           state_next;

    logic [AW-1:0]    align_cnt;
    logic [AW-1:0]    align_load;
    logic [BW-1:0]    bit_cnt;
    logic [3:0]       word_cnt;
    logic [3:0]       nwords_q;
    logic             dir_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] word_next;
    logic             word_done;
    logic             last_word;

    logic [WIDTH-1:0] buf_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;
    logic             full;
    logic             push_ok;
    logic             frame_evt;
    logic             ovf_evt;

    // Right shifts reach QR one stage later than left shifts reach QL, so the
    // align counter is preloaded with latency-1 chosen by the live dir input.
    assign align_load = dir ? AW'(DEPTH - 1) : AW'(DEPTH - 2);

    // Word assembly and the completion/last-word conditions for this cycle
    always_comb begin
        word_next = dir_q ? {ser_in, acc[WIDTH-1:1]} : {acc[WIDTH-2:0], ser_in};
        word_done = (state == COLLECT) && (bit_cnt == BW'(WIDTH - 1));
        last_word = word_done && ((word_cnt + 4'd1) == nwords_q);
    end

    // Next-state logic: idle until start, wait out the pipeline, then collect
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (align_load == '0) ? COLLECT : ALIGN;
                end
            end
            ALIGN: begin
                if (align_cnt <= AW'(1)) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (last_word) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Stream bookkeeping: latch the stream setup on start, then count bits and words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            align_cnt <= '0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            nwords_q  <= '0;
            dir_q     <= 1'b0;
            acc       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dir_q     <= dir;
                        nwords_q  <= (nwords == 3'd0) ? 4'd8 : {1'b0, nwords};
                        align_cnt <= align_load;
                        bit_cnt   <= '0;
                        word_cnt  <= '0;
                    end
                end
                ALIGN: begin
                    if (align_cnt != '0) begin
                        align_cnt <= align_cnt - AW'(1);
                    end
                end
                COLLECT: begin
                    acc <= word_next;
                    if (word_done) begin
                        bit_cnt  <= '0;
                        word_cnt <= word_cnt + 4'd1;
                    end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign push    = word_done;
    assign pop     = out_valid && out_ready;
    assign full    = (count == 2'd2);
    assign push_ok = push && (!full || pop);

    // Two-entry output FIFO; a pop in the same cycle frees room for a full-buffer push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
        end else begin
            if (push_ok) begin
                buf_mem[wr_ptr] <= word_next;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

    assign out_data  = buf_mem[rd_ptr];
    assign out_valid = (count != 2'd0);
    assign busy      = (state != IDLE);

    assign frame_evt = (state != IDLE) && (start || (dir != dir_q));
    assign ovf_evt   = push && full && !pop;

    // Sticky error flags; a new error in the clearing cycle keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overflow  <= (overflow && !clr_err) || ovf_evt;
            frame_err <= (frame_err && !clr_err) || frame_evt;
        end
    end

endmodule
